// File: rtl/jtframe_slots_pkg.sv
// Shared types for the SDRAM bank slot front-end: FSM states and slot index sizing.
package jtframe_slots_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_RDY
  } state_t;

  // Index width for a slot number, never narrower than one bit
  function automatic int slot_iw(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/jtframe_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module jtframe_rr_arbiter #(
  parameter int SLOTS = 4,
  parameter int IW    = 2
) (
  input  logic [SLOTS-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [SLOTS-1:0] o_gnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 0; k < SLOTS; k++) begin
      w_cand = IW'((int'(i_ptr) + k) % SLOTS);
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/jtframe_bank_slots.sv
// Shares one SDRAM bank port among SLOTS read-only requesters with round-robin grants.
// Define JTFRAME_SLOT_CACHE_EN to keep slot results valid after the slot's cs drops.
module jtframe_bank_slots
  import jtframe_slots_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int DW    = 16
) (
  input  logic                clk_rom,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [SLOTS*AW-1:0] slot_addr,
  input  logic [SLOTS-1:0]    slot_cs,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*DW-1:0] slot_dout,
  output logic [AW-1:0]       ba_addr,
  output logic                ba_rd,
  input  logic                ba_ack,
  input  logic                ba_rdy,
  input  logic [31:0]         sdram_dout
);

  localparam int IW = slot_iw(SLOTS);

  state_t           r_state;
  logic [AW-1:0]    r_ba_addr;
  logic             r_ba_rd;
  logic [IW-1:0]    r_sel;
  logic [IW-1:0]    r_rr;
  logic             r_flushed;
  logic [SLOTS-1:0] r_valid;
  logic [AW-1:0]    r_tag  [SLOTS];
  logic [DW-1:0]    r_dout [SLOTS];

  logic [AW-1:0]    w_addr [SLOTS];
  logic [SLOTS-1:0] w_hit;
  logic [SLOTS-1:0] w_pending;
  logic [SLOTS-1:0] w_valid_nxt;
  logic [SLOTS-1:0] w_unused_gnt;
  logic [IW-1:0]    w_gidx;
  logic             w_any;
  logic             w_done;
  logic             w_unused_dout;

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    assign w_addr[g]              = slot_addr[g*AW +: AW];
    assign w_hit[g]               = r_valid[g] & (r_tag[g] == w_addr[g]);
    assign w_pending[g]           = slot_cs[g] & ~w_hit[g];
    assign slot_ok[g]             = slot_cs[g] & w_hit[g];
    assign slot_dout[g*DW +: DW]  = r_dout[g];
  end

  assign ba_addr       = r_ba_addr;
  assign ba_rd         = r_ba_rd;
  assign w_unused_dout = ^sdram_dout;
  assign w_done        = ((r_state == WAIT_ACK) && ba_ack && ba_rdy) ||
                         ((r_state == WAIT_RDY) && ba_rdy);

  jtframe_rr_arbiter #(
    .SLOTS (SLOTS),
    .IW    (IW)
  ) u_arb (
    .i_req (w_pending),
    .i_ptr (r_rr),
    .o_gnt (w_unused_gnt),
    .o_idx (w_gidx),
    .o_any (w_any)
  );

  // Flush wins over everything, including a result landing in the same cycle
  always_comb begin
    w_valid_nxt = r_valid;
`ifdef JTFRAME_SLOT_CACHE_EN
    w_valid_nxt = r_valid;
`else
    for (int i = 0; i < SLOTS; i++) begin
      if (!slot_cs[i] && !((r_state != IDLE) && (r_sel == IW'(i))))
        w_valid_nxt[i] = 1'b0;
    end
`endif
    if (w_done)
      w_valid_nxt[r_sel] = ~(flush | r_flushed);
    if (flush)
      w_valid_nxt = '0;
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ba_addr <= '0;
      r_ba_rd   <= 1'b0;
      r_sel     <= '0;
      r_rr      <= '0;
      r_flushed <= 1'b0;
      r_valid   <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        r_tag[i]  <= '0;
        r_dout[i] <= '0;
      end
    end else begin
      r_valid <= w_valid_nxt;
      case (r_state)
        IDLE: begin
          r_flushed <= 1'b0;
          if (w_any) begin
            r_sel     <= w_gidx;
            r_ba_addr <= w_addr[w_gidx];
            r_ba_rd   <= 1'b1;
            r_state   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (flush) r_flushed <= 1'b1;
          if (ba_ack) begin
            r_ba_rd <= 1'b0;
            r_state <= ba_rdy ? IDLE : WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (flush) r_flushed <= 1'b1;
          if (ba_rdy) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // The result always lands for the latched address, even if the slot moved on
      if (w_done) begin
        r_dout[r_sel] <= sdram_dout[DW-1:0];
        r_tag[r_sel]  <= r_ba_addr;
        r_rr          <= (r_sel == IW'(SLOTS-1)) ? '0 : r_sel + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_jtframe_bank_slots.sv
// Self-checking bench for jtframe_bank_slots; acts as the SDRAM bank and models slot results.
// Expectations follow JTFRAME_SLOT_CACHE_EN when it is defined for the build.
module tb_jtframe_bank_slots;

  localparam int SLOTS = 4;
  localparam int AW    = 22;
  localparam int DW    = 16;

  logic                clk_rom = 1'b0;
  logic                rst_n = 1'b0;
  logic                flush = 1'b0;
  logic [SLOTS*AW-1:0] slot_addr = '0;
  logic [SLOTS-1:0]    slot_cs = '0;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*DW-1:0] slot_dout;
  logic [AW-1:0]       ba_addr;
  logic                ba_rd;
  logic                ba_ack = 1'b0;
  logic                ba_rdy = 1'b0;
  logic [31:0]         sdram_dout = '0;

  int total = 0;
  int bad = 0;
  int rd_rises = 0;
  logic rd_q = 1'b0;

  logic          m_valid [SLOTS];
  logic [AW-1:0] m_tag   [SLOTS];
  logic [DW-1:0] m_data  [SLOTS];
  int            m_rr;

  jtframe_bank_slots #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
    .clk_rom    (clk_rom),
    .rst_n      (rst_n),
    .flush      (flush),
    .slot_addr  (slot_addr),
    .slot_cs    (slot_cs),
    .slot_ok    (slot_ok),
    .slot_dout  (slot_dout),
    .ba_addr    (ba_addr),
    .ba_rd      (ba_rd),
    .ba_ack     (ba_ack),
    .ba_rdy     (ba_rdy),
    .sdram_dout (sdram_dout)
  );

  always #5 clk_rom = ~clk_rom;

  always @(posedge clk_rom) begin
    if (ba_rd && !rd_q) rd_rises++;
    rd_q <= ba_rd;
  end

  // Bank memory contents: upper half differs so truncation to DW is visible
  function automatic logic [31:0] bank_word(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hDEAD, a[15:0] ^ 16'hC3A5};
  endfunction

  function automatic logic [DW-1:0] bank_lo(input logic [AW-1:0] a);
    logic [31:0] w;
    w = bank_word(a);
    return w[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] dout_of(input int i);
    return slot_dout[i*DW +: DW];
  endfunction

  task automatic set_slot(input int i, input logic [AW-1:0] a, input logic cs);
    slot_addr[i*AW +: AW] = a;
    slot_cs[i] = cs;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    slot_cs = '0;
    slot_addr = '0;
    flush = 1'b0;
    ba_ack = 1'b0;
    ba_rdy = 1'b0;
    repeat (2) @(negedge clk_rom);
    rst_n = 1'b1;
    @(negedge clk_rom);
  endtask

  task automatic wait_rd(output logic seen);
    int n;
    n = 0;
    while (ba_rd !== 1'b1 && n < 20) begin
      @(negedge clk_rom);
      n++;
    end
    seen = (ba_rd === 1'b1);
  endtask

  task automatic serve(input logic [AW-1:0] exp_addr, input int ack_dly, input int rdy_dly,
                       input logic same);
    logic seen;
    logic [AW-1:0] a;
    wait_rd(seen);
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL serve_timeout ba_rd=%b required=1", ba_rd);
      return;
    end
    total++;
    if (ba_addr !== exp_addr) begin
      bad++;
      $display("[TB] FAIL grant_addr got=%h required=%h", ba_addr, exp_addr);
    end
    a = ba_addr;
    repeat (ack_dly) @(negedge clk_rom);
    ba_ack = 1'b1;
    if (same) begin
      ba_rdy = 1'b1;
      sdram_dout = bank_word(a);
    end
    @(negedge clk_rom);
    ba_ack = 1'b0;
    ba_rdy = 1'b0;
    if (!same) begin
      total++;
      if (ba_rd !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rd_after_ack got=%b required=0", ba_rd);
      end
      repeat (rdy_dly - 1) @(negedge clk_rom);
      ba_rdy = 1'b1;
      sdram_dout = bank_word(a);
      @(negedge clk_rom);
      ba_rdy = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    slot_cs = '1;
    @(negedge clk_rom);
    total++;
    if (ba_rd !== 1'b0 || ba_addr !== '0 || slot_ok !== '0 || slot_dout !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state rd=%b addr=%h ok=%b dout=%h required all zero",
               ba_rd, ba_addr, slot_ok, slot_dout);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    set_slot(0, 22'h1234, 1'b1);
    rd_rises = 0;
    @(negedge clk_rom);
    total++;
    if (ba_rd !== 1'b1 || ba_addr !== 22'h1234) begin
      bad++;
      $display("[TB] FAIL single_issue rd=%b addr=%h required 1/001234", ba_rd, ba_addr);
    end
    ba_ack = 1'b1;
    @(negedge clk_rom);
    ba_ack = 1'b0;
    repeat (2) @(negedge clk_rom);
    total++;
    if (slot_ok[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_early_ok got=%b required=0", slot_ok[0]);
    end
    ba_rdy = 1'b1;
    sdram_dout = 32'h1357_BEEF;
    @(negedge clk_rom);
    ba_rdy = 1'b0;
    total++;
    if (slot_ok[0] !== 1'b1 || dout_of(0) !== 16'hBEEF) begin
      bad++;
      $display("[TB] FAIL single_result ok=%b dout=%h required 1/beef", slot_ok[0], dout_of(0));
    end
    repeat (3) @(negedge clk_rom);
    total++;
    if (rd_rises !== 1 || slot_ok[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_one_read reads=%0d ok=%b required 1/1", rd_rises, slot_ok[0]);
    end
  endtask

  task automatic test_all_slots();
    do_reset();
    for (int i = 0; i < SLOTS; i++) set_slot(i, AW'((i + 1) * 'h100), 1'b1);
    for (int i = 0; i < SLOTS; i++) begin
      serve(AW'((i + 1) * 'h100), i % 2, 2, 1'b0);
      total++;
      if (slot_ok[i] !== 1'b1 || dout_of(i) !== bank_lo(AW'((i + 1) * 'h100))) begin
        bad++;
        $display("[TB] FAIL order_slot%0d ok=%b dout=%h required 1/%h", i, slot_ok[i],
                 dout_of(i), bank_lo(AW'((i + 1) * 'h100)));
      end
    end
    repeat (2) @(negedge clk_rom);
    total++;
    if (slot_ok !== 4'hF || ba_rd !== 1'b0) begin
      bad++;
      $display("[TB] FAIL order_all ok=%b rd=%b required f/0", slot_ok, ba_rd);
    end
  endtask

  task automatic test_addr_change();
    logic seen;
    do_reset();
    set_slot(2, 22'h10, 1'b1);
    wait_rd(seen);
    total++;
    if (!seen || ba_addr !== 22'h10) begin
      bad++;
      $display("[TB] FAIL move_first rd=%b addr=%h required 1/000010", ba_rd, ba_addr);
    end
    ba_ack = 1'b1;
    @(negedge clk_rom);
    ba_ack = 1'b0;
    set_slot(2, 22'h20, 1'b1);
    @(negedge clk_rom);
    ba_rdy = 1'b1;
    sdram_dout = bank_word(22'h10);
    @(negedge clk_rom);
    ba_rdy = 1'b0;
    total++;
    if (slot_ok[2] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL move_stale_ok got=%b required=0", slot_ok[2]);
    end
    serve(22'h20, 1, 1, 1'b0);
    total++;
    if (slot_ok[2] !== 1'b1 || dout_of(2) !== bank_lo(22'h20)) begin
      bad++;
      $display("[TB] FAIL move_second ok=%b dout=%h required 1/%h", slot_ok[2], dout_of(2),
               bank_lo(22'h20));
    end
  endtask

  task automatic test_ack_rdy_same();
    logic seen;
    do_reset();
    set_slot(3, 22'h77, 1'b1);
    wait_rd(seen);
    ba_ack = 1'b1;
    ba_rdy = 1'b1;
    sdram_dout = 32'h5555_00A5;
    @(negedge clk_rom);
    ba_ack = 1'b0;
    ba_rdy = 1'b0;
    total++;
    if (!seen || slot_ok[3] !== 1'b1 || dout_of(3) !== 16'h00A5 || ba_rd !== 1'b0) begin
      bad++;
      $display("[TB] FAIL same_cycle ok=%b dout=%h rd=%b required 1/00a5/0", slot_ok[3],
               dout_of(3), ba_rd);
    end
    set_slot(0, 22'h5, 1'b1);
    @(negedge clk_rom);
    total++;
    if (ba_rd !== 1'b1 || ba_addr !== 22'h5) begin
      bad++;
      $display("[TB] FAIL same_cycle_idle rd=%b addr=%h required 1/000005", ba_rd, ba_addr);
    end
  endtask

  task automatic test_cache_reuse();
    logic exp_hit;
`ifdef JTFRAME_SLOT_CACHE_EN
    exp_hit = 1'b1;
`else
    exp_hit = 1'b0;
`endif
    do_reset();
    set_slot(1, 22'h40, 1'b1);
    serve(22'h40, 0, 2, 1'b0);
    slot_cs[1] = 1'b0;
    repeat (2) @(negedge clk_rom);
    slot_cs[1] = 1'b1;
    #1;
    total++;
    if (slot_ok[1] !== exp_hit) begin
      bad++;
      $display("[TB] FAIL reuse_ok got=%b required=%b", slot_ok[1], exp_hit);
    end
    @(negedge clk_rom);
    total++;
    if (ba_rd !== !exp_hit) begin
      bad++;
      $display("[TB] FAIL reuse_rd got=%b required=%b", ba_rd, !exp_hit);
    end
    if (!exp_hit) serve(22'h40, 0, 1, 1'b0);
    total++;
    if (slot_ok[1] !== 1'b1 || dout_of(1) !== bank_lo(22'h40)) begin
      bad++;
      $display("[TB] FAIL reuse_final ok=%b dout=%h required 1/%h", slot_ok[1], dout_of(1),
               bank_lo(22'h40));
    end
  endtask

  task automatic test_flush_reset();
    logic seen;
    do_reset();
    set_slot(0, 22'h300, 1'b1);
    wait_rd(seen);
    ba_ack = 1'b1;
    @(negedge clk_rom);
    ba_ack = 1'b0;
    flush = 1'b1;
    @(negedge clk_rom);
    flush = 1'b0;
    ba_rdy = 1'b1;
    sdram_dout = bank_word(22'h300);
    @(negedge clk_rom);
    ba_rdy = 1'b0;
    total++;
    if (slot_ok[0] !== 1'b0 || dout_of(0) !== bank_lo(22'h300)) begin
      bad++;
      $display("[TB] FAIL flush_inflight ok=%b dout=%h required 0/%h", slot_ok[0], dout_of(0),
               bank_lo(22'h300));
    end
    wait_rd(seen);
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL flush_rerequest rd=%b required=1", ba_rd);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ba_rd !== 1'b0 || ba_addr !== '0 || slot_ok !== '0 || slot_dout !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset rd=%b addr=%h ok=%b dout=%h required all zero",
               ba_rd, ba_addr, slot_ok, slot_dout);
    end
    slot_cs = '0;
    @(negedge clk_rom);
    rst_n = 1'b1;
    @(negedge clk_rom);
    total++;
    if (ba_rd !== 1'b0) begin
      bad++;
      $display("[TB] FAIL post_reset_rd got=%b required=0", ba_rd);
    end
  endtask

  task automatic test_random();
    do_reset();
    m_rr = 0;
    for (int i = 0; i < SLOTS; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i] = '0;
      m_data[i] = '0;
    end
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < SLOTS; i++)
        set_slot(i, AW'(32'h1A0 + 32'h111 * $urandom_range(0, 3)), 1'($urandom_range(0, 1)));
`ifndef JTFRAME_SLOT_CACHE_EN
      for (int i = 0; i < SLOTS; i++) if (!slot_cs[i]) m_valid[i] = 1'b0;
`endif
      for (int t = 0; t < SLOTS; t++) begin
        int g;
        logic [AW-1:0] ga;
        g = -1;
        for (int k = 0; k < SLOTS; k++) begin
          int c;
          c = (m_rr + k) % SLOTS;
          if (g < 0 && slot_cs[c] && !(m_valid[c] && m_tag[c] == slot_addr[c*AW +: AW])) g = c;
        end
        if (g < 0) break;
        ga = slot_addr[g*AW +: AW];
        serve(ga, $urandom_range(0, 2), $urandom_range(1, 3), ($urandom_range(0, 3) == 0));
        m_valid[g] = 1'b1;
        m_tag[g] = ga;
        m_data[g] = bank_lo(ga);
        m_rr = (g + 1) % SLOTS;
        total++;
        if (slot_ok[g] !== 1'b1 || dout_of(g) !== m_data[g]) begin
          bad++;
          $display("[TB] FAIL rand_fill r=%0d slot=%0d ok=%b dout=%h required 1/%h", r, g,
                   slot_ok[g], dout_of(g), m_data[g]);
        end
      end
      repeat (2) @(negedge clk_rom);
      total++;
      if (ba_rd !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rand_idle r=%0d rd=%b required=0", r, ba_rd);
      end
      for (int i = 0; i < SLOTS; i++) begin
        logic exp_ok;
        exp_ok = slot_cs[i] && m_valid[i] && (m_tag[i] == slot_addr[i*AW +: AW]);
        total++;
        if (slot_ok[i] !== exp_ok || dout_of(i) !== m_data[i]) begin
          bad++;
          $display("[TB] FAIL rand_state r=%0d slot=%0d ok=%b dout=%h required %b/%h", r, i,
                   slot_ok[i], dout_of(i), exp_ok, m_data[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_all_slots();
    test_addr_change();
    test_ack_rdy_same();
    test_cache_reuse();
    test_flush_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
